// File: rtl/imm_gen_stage.sv
// imm_gen_stage: decode-stage immediate generator.
// Extends the I/S/B/U/J/CSR-Z immediate of each accepted instruction to XLEN
// and holds it, with its sideband tag, in a two-entry skid buffer so that
// in_ready is a function of registered state only.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       ImmSrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_ext,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   main_imm_q, main_imm_d;
    logic [TAG_W-1:0]  main_tag_q, main_tag_d;
    logic              main_ill_q, main_ill_d;
    logic [XLEN-1:0]   skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0]  skid_tag_q, skid_tag_d;
    logic              skid_ill_q, skid_ill_d;

    logic [31:0]       imm32;
    logic              ext_bit;
    logic              new_ill;
    logic [XLEN-1:0]   imm_new;
    logic              in_xfer;
    logic              out_xfer;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign imm_ext   = main_imm_q;
    assign out_tag   = main_tag_q;
    assign illegal   = main_ill_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // Build the 32-bit immediate plus the bit that fills everything above it;
    // the signed cast then widens (or trims) to XLEN in one place.
    always_comb begin
        imm32   = 32'd0;
        ext_bit = 1'b0;
        new_ill = 1'b0;
        case (ImmSrc)
            3'b000: begin
                imm32   = {{20{instr[31]}}, instr[31:20]};
                ext_bit = instr[31];
            end
            3'b001: begin
                imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                ext_bit = instr[31];
            end
            3'b010: begin
                imm32   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                ext_bit = instr[31];
            end
            3'b011: begin
                imm32   = {instr[31:12], 12'd0};
                ext_bit = instr[31];
            end
            3'b100: begin
                imm32   = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                ext_bit = instr[31];
            end
            3'b101: begin
                imm32   = {27'd0, instr[19:15]};
                ext_bit = 1'b0;
            end
            default: begin
                new_ill = 1'b1;
            end
        endcase
        imm_new = XLEN'($signed({ext_bit, imm32}));
    end

    // Next-state and entry movement: main is the presented entry, skid only
    // fills when main is stalled, and flush overrides both transfers.
    always_comb begin
        state_d    = state_q;
        main_imm_d = main_imm_q;
        main_tag_d = main_tag_q;
        main_ill_d = main_ill_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;
        skid_ill_d = skid_ill_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d    = ONE;
                        main_imm_d = imm_new;
                        main_tag_d = in_tag;
                        main_ill_d = new_ill;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_imm_d = imm_new;
                        main_tag_d = in_tag;
                        main_ill_d = new_ill;
                    end else if (in_xfer) begin
                        state_d    = TWO;
                        skid_imm_d = imm_new;
                        skid_tag_d = in_tag;
                        skid_ill_d = new_ill;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        state_d    = ONE;
                        main_imm_d = skid_imm_q;
                        main_tag_d = skid_tag_q;
                        main_ill_d = skid_ill_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and the presented entry clear on reset since they are observable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            main_imm_q <= '0;
            main_tag_q <= '0;
            main_ill_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_imm_q <= main_imm_d;
            main_tag_q <= main_tag_d;
            main_ill_q <= main_ill_d;
        end
    end

    // The skid entry is only read in TWO, which reset cannot leave us in.
    always_ff @(posedge clk) begin
        skid_imm_q <= skid_imm_d;
        skid_tag_q <= skid_tag_d;
        skid_ill_q <= skid_ill_d;
    end

endmodule
